// File: rtl/audio_capture_packer_if.sv
// audio_capture_packer_if: codec read-FIFO handshake plus Avalon-MM write-master bus
interface audio_capture_packer_if #(
    parameter int ADDR_W = 23
);
    logic              read_ready;
    logic [15:0]       readdata_left;
    logic [15:0]       readdata_right;
    logic              read_s;
    logic              mem_waitrequest;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_writedata;
    logic [3:0]        mem_byteenable;
    modport master (
        input  read_ready, readdata_left, readdata_right, mem_waitrequest,
        output read_s, mem_write, mem_address, mem_writedata, mem_byteenable
    );
    modport slave (
        output read_ready, readdata_left, readdata_right, mem_waitrequest,
        input  read_s, mem_write, mem_address, mem_writedata, mem_byteenable
    );
endinterface

// File: rtl/audio_capture_packer.sv
// audio_capture_packer: pops codec samples, packs pairs into 32-bit words, writes them over Avalon-MM
module audio_capture_packer #(
    parameter int ADDR_W    = 23,
    parameter int NUM_WORDS = 1048576
) (
    input  logic                   CLOCK_50,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   sel_right,
    input  logic [1:0]             rate,
    audio_capture_packer_if.master bus,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_W-1:0]      words_written
);
    typedef enum logic [3:0] {
        S_IDLE, S_WAIT, S_CAPTURE, S_ACK, S_RATE, S_PACK, S_WRITE, S_NEXT, S_DONE
    } state_t;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_WORDS - 1);
    state_t            state_q, state_d;
    logic [15:0]       sample_q, sample_d;
    logic              half_q, half_d, drop_q, drop_d, dup_q, dup_d;
    logic [ADDR_W-1:0] addr_q, addr_d, count_q, count_d;
    logic [31:0]       data_q, data_d;
    logic              last;
    assign last = addr_q == LAST;
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            sample_q <= '0;
            half_q   <= 1'b0;
            drop_q   <= 1'b0;
            dup_q    <= 1'b0;
            addr_q   <= '0;
            count_q  <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            sample_q <= sample_d;
            half_q   <= half_d;
            drop_q   <= drop_d;
            dup_q    <= dup_d;
            addr_q   <= addr_d;
            count_q  <= count_d;
            data_q   <= data_d;
        end
    end
    always_comb begin
        state_d  = state_q;
        sample_d = sample_q;
        half_d   = half_q;
        drop_d   = drop_q;
        dup_d    = dup_q;
        addr_d   = addr_q;
        count_d  = count_q;
        data_d   = data_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) begin
                state_d = S_WAIT;
                addr_d  = '0;
                count_d = '0;
                half_d  = 1'b0;
                drop_d  = 1'b0;
                dup_d   = 1'b0;
            end
            S_WAIT:    state_d = abort ? S_DONE : (bus.read_ready ? S_CAPTURE : S_WAIT);
            S_CAPTURE: begin
                state_d  = S_ACK;
                sample_d = sel_right ? bus.readdata_right : bus.readdata_left;
            end
            S_ACK:     state_d = bus.read_ready ? S_ACK : S_RATE;
            S_RATE: begin
                drop_d  = (rate == 2'b01) ? !drop_q : drop_q;
                state_d = (rate == 2'b01 && drop_q) ? S_WAIT : S_PACK;
            end
            // dup marks a pending second copy; it clears on the PACK that consumes it
            S_PACK: begin
                dup_d   = rate == 2'b10 && !dup_q;
                half_d  = !half_q;
                data_d  = half_q ? {sample_q, data_q[15:0]} : {data_q[31:16], sample_q};
                state_d = half_q ? S_WRITE : (dup_d ? S_PACK : S_WAIT);
            end
            S_WRITE: if (!bus.mem_waitrequest) begin
                state_d = S_NEXT;
                count_d = count_q + ADDR_W'(1);
            end
            S_NEXT: begin
                state_d = (last || abort) ? S_DONE : (dup_q ? S_PACK : S_WAIT);
                addr_d  = (last || abort) ? addr_q : addr_q + ADDR_W'(1);
            end
            default:   state_d = S_IDLE;
        endcase
    end
    always_comb begin
        bus.read_s         = state_q == S_CAPTURE || state_q == S_ACK;
        bus.mem_write      = state_q == S_WRITE;
        bus.mem_address    = addr_q;
        bus.mem_writedata  = data_q;
        bus.mem_byteenable = 4'b1111;
        busy               = state_q != S_IDLE && state_q != S_DONE;
        done               = state_q == S_DONE;
        words_written      = count_q;
    end
endmodule

// File: tb/tb_audio_capture_packer.sv
// tb_audio_capture_packer: directed recording vectors plus stall, end-of-buffer, abort and reset sequences
module tb_audio_capture_packer;
    logic        CLOCK_50 = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, abort = 1'b0, sel_right = 1'b0;
    logic [1:0]  rate = 2'b00;
    logic        busy, done;
    logic [22:0] words_written;
    int          errors = 0, checks = 0;

    typedef struct {
        logic [22:0] a;
        logic [31:0] d;
    } wr_t;
    wr_t wq[$];

    typedef struct {
        logic [1:0]        rate;
        logic              sel;
        int                n;
        logic [3:0][15:0]  s;
        int                nw;
        logic [1:0][31:0]  w;
    } vec_t;
    vec_t v[6];

    audio_capture_packer_if #(.ADDR_W(23)) bus ();

    audio_capture_packer #(.ADDR_W(23), .NUM_WORDS(4)) dut (
        .CLOCK_50(CLOCK_50), .rst_n(rst_n), .start(start), .abort(abort),
        .sel_right(sel_right), .rate(rate), .bus(bus),
        .busy(busy), .done(done), .words_written(words_written)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50)
        if (rst_n && bus.mem_write && !bus.mem_waitrequest)
            wq.push_back('{bus.mem_address, bus.mem_writedata});

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge CLOCK_50) start = 1'b1;
        @(negedge CLOCK_50) start = 1'b0;
    endtask

    task automatic feed(input logic [15:0] l, input logic [15:0] r);
        int t = 0;
        @(negedge CLOCK_50);
        bus.readdata_left = l;
        bus.readdata_right = r;
        bus.read_ready = 1'b1;
        while (!bus.read_s && t < 200) begin @(negedge CLOCK_50); t++; end
        chk("read_s_timeout", 32'(t >= 200), 32'd0);
        bus.read_ready = 1'b0;
        t = 0;
        while (bus.read_s && t < 50) begin @(negedge CLOCK_50); t++; end
        chk("read_s_release_timeout", 32'(t >= 50), 32'd0);
    endtask

    task automatic wait_done(input int budget);
        int t = 0;
        while (!done && t < budget) begin @(negedge CLOCK_50); t++; end
        chk("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic finish_rec();
        repeat (20) @(negedge CLOCK_50);
        abort = 1'b1;
        wait_done(50);
        abort = 1'b0;
    endtask

    initial begin
        logic [15:0] s;
        logic        rs_seen;
        int          t;
        v[0] = '{2'b00, 1'b0, 4, {16'h4444, 16'h3333, 16'h2222, 16'h1111}, 2, {32'h44443333, 32'h22221111}};
        v[1] = '{2'b01, 1'b0, 4, {16'h000D, 16'h000C, 16'h000B, 16'h000A}, 1, {32'h0, 32'h000C000A}};
        v[2] = '{2'b10, 1'b0, 2, {16'h0, 16'h0, 16'h0006, 16'h0005}, 2, {32'h00060006, 32'h00050005}};
        v[3] = '{2'b00, 1'b1, 2, {16'h0, 16'h0, 16'hCAFE, 16'hBEEF}, 1, {32'h0, 32'hCAFEBEEF}};
        v[4] = '{2'b11, 1'b0, 2, {16'h0, 16'h0, 16'h8000, 16'h0001}, 1, {32'h0, 32'h80000001}};
        v[5] = '{2'b00, 1'b0, 3, {16'h0, 16'h3333, 16'h2222, 16'h1111}, 1, {32'h0, 32'h22221111}};
        bus.read_ready = 1'b0;
        bus.readdata_left = '0;
        bus.readdata_right = '0;
        bus.mem_waitrequest = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
        chk("rst_read_s", 32'(bus.read_s), 32'd0);
        chk("rst_busy_done", {busy, done}, 32'd0);
        chk("rst_addr_data", 32'(bus.mem_address) | bus.mem_writedata, 32'd0);
        chk("rst_words", 32'(words_written), 32'd0);
        chk("byteenable", 32'(bus.mem_byteenable), 32'hF);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            rate = v[i].rate;
            sel_right = v[i].sel;
            wq.delete();
            pulse_start();
            chk($sformatf("v%0d_busy", i), {busy, done}, 32'd2);
            for (int k = 0; k < v[i].n; k++) begin
                s = v[i].s[k];
                feed(v[i].sel ? ~s : s, v[i].sel ? s : ~s);
            end
            finish_rec();
            chk($sformatf("v%0d_nwrites", i), wq.size(), v[i].nw);
            for (int j = 0; j < v[i].nw && j < wq.size(); j++) begin
                chk($sformatf("v%0d_addr%0d", i, j), 32'(wq[j].a), j);
                chk($sformatf("v%0d_data%0d", i, j), wq[j].d, v[i].w[j]);
            end
            chk($sformatf("v%0d_words", i), 32'(words_written), v[i].nw);
            chk($sformatf("v%0d_done", i), {busy, done}, 32'd1);
        end

        // waitrequest stall: 7 stalled cycles, transfer on the 8th
        rate = 2'b00;
        sel_right = 1'b0;
        wq.delete();
        bus.mem_waitrequest = 1'b1;
        pulse_start();
        feed(16'h1234, 16'h0);
        feed(16'h5678, 16'h0);
        t = 0;
        while (!bus.mem_write && t < 20) begin @(negedge CLOCK_50); t++; end
        chk("stall_write_timeout", 32'(bus.mem_write), 32'd1);
        for (int i = 0; i < 8; i++) begin
            if (i == 0) begin bus.readdata_left = 16'h9999; bus.read_ready = 1'b1; end
            chk($sformatf("stall_write_c%0d", i), 32'(bus.mem_write), 32'd1);
            chk($sformatf("stall_addr_c%0d", i), 32'(bus.mem_address), 32'd0);
            chk($sformatf("stall_data_c%0d", i), bus.mem_writedata, 32'h56781234);
            chk($sformatf("stall_read_s_c%0d", i), 32'(bus.read_s), 32'd0);
            if (i == 7) begin bus.mem_waitrequest = 1'b0; bus.read_ready = 1'b0; end
            @(negedge CLOCK_50);
        end
        chk("stall_write_after", 32'(bus.mem_write), 32'd0);
        chk("stall_words", 32'(words_written), 32'd1);
        chk("stall_nwrites", wq.size(), 32'd1);
        finish_rec();

        // fill all four words of the buffer
        wq.delete();
        pulse_start();
        for (int k = 0; k < 8; k++) feed(16'h0100 + 16'(k), 16'h0);
        wait_done(50);
        chk("full_nwrites", wq.size(), 32'd4);
        for (int j = 0; j < 4 && j < wq.size(); j++) begin
            chk($sformatf("full_addr%0d", j), 32'(wq[j].a), j);
            chk($sformatf("full_data%0d", j), wq[j].d, {16'h0101 + 16'(2 * j), 16'h0100 + 16'(2 * j)});
        end
        chk("full_busy_done", {busy, done}, 32'd1);
        chk("full_mem_address", 32'(bus.mem_address), 32'd3);
        chk("full_words", 32'(words_written), 32'd4);
        rs_seen = 1'b0;
        bus.read_ready = 1'b1;
        repeat (10) begin @(negedge CLOCK_50); rs_seen |= bus.read_s; end
        bus.read_ready = 1'b0;
        chk("full_ignore_read_s", 32'(rs_seen), 32'd0);
        chk("full_ignore_writes", wq.size(), 32'd4);
        wq.delete();
        pulse_start();
        chk("restart_addr", 32'(bus.mem_address), 32'd0);
        feed(16'hAAAA, 16'h0);
        feed(16'hBBBB, 16'h0);
        t = 0;
        while (wq.size() == 0 && t < 20) begin @(negedge CLOCK_50); t++; end
        chk("restart_nwrites", wq.size(), 32'd1);
        if (wq.size() > 0) begin
            chk("restart_waddr", 32'(wq[0].a), 32'd0);
            chk("restart_wdata", wq[0].d, 32'hBBBBAAAA);
        end
        finish_rec();

        // async reset in the middle of the second write
        wq.delete();
        pulse_start();
        feed(16'h0011, 16'h0);
        feed(16'h0022, 16'h0);
        feed(16'h0033, 16'h0);
        bus.mem_waitrequest = 1'b1;
        feed(16'h0044, 16'h0);
        t = 0;
        while (!bus.mem_write && t < 20) begin @(negedge CLOCK_50); t++; end
        chk("rstw_write", 32'(bus.mem_write), 32'd1);
        chk("rstw_addr", 32'(bus.mem_address), 32'd1);
        chk("rstw_words", 32'(words_written), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstw_mem_write", 32'(bus.mem_write), 32'd0);
        chk("rstw_addr0", 32'(bus.mem_address), 32'd0);
        chk("rstw_data0", bus.mem_writedata, 32'd0);
        chk("rstw_busy_done", {busy, done}, 32'd0);
        chk("rstw_words0", 32'(words_written), 32'd0);
        chk("rstw_read_s", 32'(bus.read_s), 32'd0);
        @(negedge CLOCK_50);
        bus.mem_waitrequest = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        chk("rstw_idle", {busy, done}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
